// File: rtl/conv2_job_scheduler.sv
// conv2_job_scheduler: sequences 8x4 conv2 kernel jobs through one shared engine, building per-output-channel post-sums.
module conv2_job_scheduler #(
  parameter int N_IN    = 4,
  parameter int N_OUT   = 8,
  parameter int TIMEOUT = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       eng_done,
  output logic       eng_start,
  output logic [4:0] kernel_idx,
  output logic [1:0] in_ch_sel,
  output logic [2:0] out_ch,
  output logic       acc_clear,
  output logic       acc_en,
  output logic       ch_wr,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACC, WRITE, FINISH, ERR} state_t;
  state_t state;
  logic [1:0] ic;
  logic [2:0] oc;
  logic [TW-1:0] timer;
  assign kernel_idx = 5'(32'(oc) * N_IN + 32'(ic));
  assign in_ch_sel = ic;
  assign out_ch = oc;
  // Pulses are set on the transition into the state that owns them, so every output is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ic <= '0;
      oc <= '0;
      timer <= '0;
      eng_start <= 1'b0;
      acc_clear <= 1'b0;
      acc_en <= 1'b0;
      ch_wr <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      acc_clear <= 1'b0;
      acc_en <= 1'b0;
      ch_wr <= 1'b0;
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
        busy <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            oc <= '0;
            ic <= '0;
            err <= 1'b0;
            busy <= 1'b1;
            eng_start <= 1'b1;
            acc_clear <= 1'b1;
            state <= ISSUE;
          end
          ISSUE: begin
            timer <= '0;
            state <= WAIT;
          end
          WAIT: if (eng_done) begin
            acc_en <= 1'b1;
            state <= ACC;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            err <= 1'b1;
            state <= ERR;
          end else begin
            timer <= timer + TW'(1);
          end
          ACC: if (ic == 2'(N_IN - 1)) begin
            ch_wr <= 1'b1;
            state <= WRITE;
          end else begin
            ic <= ic + 2'd1;
            eng_start <= 1'b1;
            state <= ISSUE;
          end
          WRITE: if (oc == 3'(N_OUT - 1)) begin
            done <= 1'b1;
            state <= FINISH;
          end else begin
            oc <= oc + 3'd1;
            ic <= '0;
            eng_start <= 1'b1;
            acc_clear <= 1'b1;
            state <= ISSUE;
          end
          default: begin
            busy <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/conv2_job_scheduler.md
# conv2_job_scheduler

Sequencer for a single shared second-layer convolution engine that replaces the fully parallel 32-instance conv2 array. It walks all 32 (output-channel, input-channel) kernel jobs, 8 output channels by 4 input channels, and handshakes each job with the engine. It drives the kernel/channel selects and the accumulator controls that build each output channel's post-sum. It strobes each completed output channel to the ReLU2/maxpool2 stage, and it reports frame completion or an engine timeout.

## Interface
Parameters:
- N_IN, 4, input channels summed per output channel (maxpool1 outputs)
- N_OUT, 8, output channels per frame
- TIMEOUT, 256, maximum WAIT cycles per job before error

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  frame request; accepted only in IDLE
- abort  in  1  synchronous abort; returns to IDLE from any non-IDLE state
- eng_done  in  1  engine result valid; sampled only in WAIT
- eng_start  out  1  one-cycle engine launch pulse
- kernel_idx  out  5  oc*N_IN + ic; selects the kernel_2 weight set
- in_ch_sel  out  2  ic; selects the maxpool1 feature map
- out_ch  out  3  oc; selects the post-sum accumulator
- acc_clear  out  1  with eng_start when ic==0; accumulator loads instead of adds
- acc_en  out  1  one-cycle pulse; accumulator captures the engine result
- ch_wr  out  1  one-cycle pulse; post-sum for out_ch complete, pushed to ReLU2
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle frame-complete pulse
- err  out  1  sticky timeout flag; cleared by an accepted start or rst

## Operation
- States: IDLE, ISSUE, WAIT, ACC, WRITE, FINISH, ERR. All outputs are registered or decoded from the registered state (Moore). No combinational path from inputs to outputs.
- IDLE: on start, clear oc, ic and err, then go to ISSUE. eng_done is ignored.
- ISSUE (1 cycle): eng_start=1 and acc_clear=(ic==0). Clear the wait timer, then go to WAIT.
- WAIT: if eng_done, go to ACC. Otherwise increment the timer. After TIMEOUT WAIT cycles with no eng_done, go to ERR. If eng_done arrives in the same cycle the timeout would fire, eng_done wins.
- ACC (1 cycle): acc_en=1. If ic==N_IN-1, go to WRITE; otherwise ic++ and go to ISSUE.
- WRITE (1 cycle): ch_wr=1. If oc==N_OUT-1, go to FINISH; otherwise oc++, ic=0, and go to ISSUE.
- FINISH (1 cycle): done=1, then go to IDLE.
- ERR (1 cycle): err set and held sticky; then go to IDLE. No done pulse.
- kernel_idx, in_ch_sel and out_ch are stable from ISSUE through ACC of each job, and out_ch is stable through WRITE.
- Job order: oc outer, ic inner. kernel_idx runs 0,1,...,31 in sequence.
- start while busy is ignored and not queued. eng_done outside WAIT is ignored.
- abort in any non-IDLE state: go to IDLE next cycle. No done, no ch_wr; all pulses are low from that cycle; err is unchanged. abort in IDLE has no effect. If abort and start are both high in IDLE, start is accepted.
- Timer width is clog2(TIMEOUT)+1. Counter arithmetic is unsigned.

## Timing
- Reset values: state=IDLE, oc=ic=0, timer=0, and all outputs 0 (eng_start, kernel_idx, in_ch_sel, out_ch, acc_clear, acc_en, ch_wr, busy, done, err).
- start sampled at cycle t0: busy rises at t0+1 and the first ISSUE is at t0+1.
- Engine latency L ≥ 1 means eng_done is high L cycles after its eng_start cycle.
- Per job: ISSUE at t, ACC at t+L+1, next ISSUE or WRITE at t+L+2, so each job costs L+2 cycles.
- Per output channel: 4(L+2)+1 cycles. The frame's FINISH/done is at t0+1+32(L+2)+8. For L=1 that is t0+105.
- busy falls in the cycle after FINISH, ERR, or abort.
- Timeout: with no eng_done, ERR and err are at t+1+TIMEOUT relative to ISSUE at t; for the first job this is t0+258 with the default TIMEOUT.
- rst asserted mid-frame forces the reset values immediately (asynchronous). The next start after rst release runs a full frame.

## Test plan
- Normal frame with L=1, start at t0:
  - eng_start pulses 32 times; kernel_idx runs 0..31.
  - acc_clear is high on kernel_idx 0,4,...,28.
  - ch_wr pulses 8 times with out_ch 0..7.
  - done is a single pulse at t0+105; busy is low at t0+106; err=0.
- Variable latency: L drawn randomly from 1..20 per job. Check job order and the counts of eng_start, acc_en and ch_wr (32/32/8). done comes 1 cycle after the last WRITE.
- Timeout: eng_done held low.
  - err and ERR at t0+258; busy low at t0+259; no done; err stays high.
  - A subsequent start clears err at acceptance and the frame completes normally.
- Abort: assert abort during WAIT of kernel_idx 13. busy is low next cycle; no further ch_wr or done.
- Abort + restart: after the abort above, a new start runs a full frame from kernel_idx 0.
- Ignored inputs and mid-frame reset:
  - start pulsed at kernel_idx 5 does not restart the frame; eng_done pulsed in IDLE and in ACC is ignored.
  - rst asserted mid-frame forces all outputs to 0 within the same cycle.
